wb_unified_mem_arbiter: RTL

WB_UNIFIED_MEM_ARBITER -- requirements
Module: wb_unified_mem_arbiter

---
 rtl/wb_unified_mem_arbiter_pkg.sv | 32 +++
 rtl/wb_unified_mem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_unified_mem_arbiter_pkg.sv
// rtl/wb_unified_mem_arbiter_pkg.sv - shared states, grant codes and bus constants for the memory arbiter
package wb_unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // grant codes are one-hot {data, instr}
    localparam logic [1:0]  GRANT_NONE = 2'b00;
    localparam logic [1:0]  GRANT_I    = 2'b01;
    localparam logic [1:0]  GRANT_D    = 2'b10;

    localparam logic [3:0]  SEL_NONE   = 4'h0;
    localparam logic [3:0]  SEL_WORD   = 4'hF;
    localparam logic [31:0] WORD_NOP   = 32'h0000_0000;

    // Winner when both masters request in the same idle cycle.
    function automatic arb_state_e tie_winner(input logic round_robin, input owner_e last);
        if (round_robin && (last == OWNER_D)) begin
            return ST_GNT_I;
        end
        return ST_GNT_D;
    endfunction

endpackage

// File: rtl/wb_unified_mem_arbiter.sv
// rtl/wb_unified_mem_arbiter.sv - two-master (instr/data) Wishbone arbiter onto one memory slave
module wb_unified_mem_arbiter
    import wb_unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          ROUND_ROBIN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,

    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_we_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,

    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,

    output logic [1:0]  grant_o
);

    localparam bit         TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    arb_state_e  state, state_nxt;
    owner_e      last_grant, last_grant_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;

    logic i_req, d_req;
    logic own_cyc;
    logic timeout_hit;
    logic owner_ack, owner_err;

    assign i_req = iwb_cyc_i & iwb_stb_i;
    assign d_req = dwb_cyc_i & dwb_stb_i;

    assign own_cyc = (state == ST_GNT_I) ? iwb_cyc_i :
                     (state == ST_GNT_D) ? dwb_cyc_i : 1'b0;

    // A real slave response in the limit cycle takes precedence over the timeout.
    assign timeout_hit = TIMEOUT_EN && (state != ST_IDLE) && (wait_cnt == TIMEOUT_LIMIT)
                         && !m_ack_i && !m_err_i;

    // Responses reach the owner only while it still holds its cycle; err beats ack.
    assign owner_err = own_cyc & (m_err_i | timeout_hit);
    assign owner_ack = own_cyc & m_ack_i & ~m_err_i & ~timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= OWNER_I;
            wait_cnt   <= 16'd0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        unique case (state)
            ST_IDLE: begin
                wait_cnt_nxt = 16'd0;
                if (i_req && d_req) begin
                    state_nxt = tie_winner(ROUND_ROBIN, last_grant);
                end else if (i_req) begin
                    state_nxt = ST_GNT_I;
                end else if (d_req) begin
                    state_nxt = ST_GNT_D;
                end
                if (state_nxt == ST_GNT_I) begin
                    last_grant_nxt = OWNER_I;
                end else if (state_nxt == ST_GNT_D) begin
                    last_grant_nxt = OWNER_D;
                end
            end
            default: begin
                if (!own_cyc || m_ack_i || m_err_i || timeout_hit) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = 16'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        m_adr_o   = WORD_NOP;
        m_dat_o   = WORD_NOP;
        m_sel_o   = SEL_NONE;
        m_we_o    = 1'b0;
        m_cyc_o   = 1'b0;
        m_stb_o   = 1'b0;
        iwb_dat_o = WORD_NOP;
        iwb_ack_o = 1'b0;
        iwb_err_o = 1'b0;
        dwb_dat_o = WORD_NOP;
        dwb_ack_o = 1'b0;
        dwb_err_o = 1'b0;
        grant_o   = GRANT_NONE;
        unique case (state)
            ST_GNT_I: begin
                // instruction fetches are always full-word reads
                m_adr_o   = iwb_adr_i;
                m_sel_o   = SEL_WORD;
                m_cyc_o   = iwb_cyc_i & ~timeout_hit;
                m_stb_o   = iwb_stb_i & ~timeout_hit;
                iwb_dat_o = m_dat_i;
                iwb_ack_o = owner_ack;
                iwb_err_o = owner_err;
                grant_o   = GRANT_I;
            end
            ST_GNT_D: begin
                m_adr_o   = dwb_adr_i;
                m_dat_o   = dwb_dat_i;
                m_sel_o   = dwb_sel_i;
                m_we_o    = dwb_we_i;
                m_cyc_o   = dwb_cyc_i & ~timeout_hit;
                m_stb_o   = dwb_stb_i & ~timeout_hit;
                dwb_dat_o = m_dat_i;
                dwb_ack_o = owner_ack;
                dwb_err_o = owner_err;
                grant_o   = GRANT_D;
            end
            default: ;
        endcase
    end

endmodule
